// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state encoding shared by the UART transmitter and receiver
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLKS_PER_BIT = 434;
  typedef logic [2:0] uart_state_t;
  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter ticking bit_end on the last clock of each bit
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q;
  assign bit_end = cnt_q == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    if (rst || clear) cnt_q <= '0;
    else cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: valid/ready byte input serialised LSB-first as start, 8 data, optional parity, 1-2 stop bits
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx_out,
  output logic                      tx_busy,
  output logic                      tx_done
);
  uart_state_t state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic stop_idx_q, stop_idx_d;
  logic par_q, par_d, busy_q, busy_d, out_q, out_d;
  logic bit_end, accept, last_stop;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clear(state_q == ST_IDLE),
    .bit_end(bit_end)
  );
  assign tx_ready  = state_q == ST_IDLE && !rst;
  assign accept    = tx_valid && tx_ready;
  assign last_stop = stop_idx_q == 1'(STOP_BITS - 1);
  assign tx_done   = state_q == ST_STOP && bit_end && last_stop && !rst;
  assign tx_busy   = busy_q;
  assign tx_out    = out_q;
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d   = ST_START;
        shift_d   = tx_data;
        par_d     = ^tx_data ^ (PARITY_ODD != 0);
        busy_d    = 1'b1;
        bit_idx_d = '0;
      end
      ST_START: if (bit_end) begin
        state_d   = ST_DATA;
        bit_idx_d = '0;
      end
      ST_DATA: if (bit_end) begin
        shift_d   = shift_q >> 1;
        bit_idx_d = bit_idx_q + 1'b1;
        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
          state_d    = PARITY_EN != 0 ? ST_PARITY : ST_STOP;
          stop_idx_d = 1'b0;
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d    = ST_STOP;
        stop_idx_d = 1'b0;
      end
      ST_STOP: if (bit_end) begin
        state_d    = last_stop ? ST_IDLE : ST_STOP;
        stop_idx_d = last_stop ? 1'b0 : stop_idx_q + 1'b1;
        busy_d     = !last_stop;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // pin level is registered from the next state so it changes exactly on bit boundaries
    out_d = state_d == ST_START  ? 1'b0 :
            state_d == ST_DATA   ? shift_d[0] :
            state_d == ST_PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      busy_q     <= 1'b0;
      out_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
    end
endmodule
